cdb_arbiter: RTL and testbench

//  Schedules the common data bus (CDB). Per-source queues accept results from the RS/ALU

---
 rtl/cdb_arbiter_pkg.sv | 16 +
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/cdb_fifo.sv | 57 +++++
 rtl/cdb_arbiter.sv | 92 +++++++++
 tb/tb_cdb_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter.
//   ROB_WIDTH / DATA_WIDTH : default tag and result widths
//   CDB_NUM_SRC            : default number of result producers
//   CDB_SRC_RS / LSB       : producer indices on the bus
//   cdb_src_w()            : width of a source index (never below 1 bit)
package cdb_arbiter_pkg;
  localparam int ROB_WIDTH   = 5;
  localparam int DATA_WIDTH  = 32;
  localparam int CDB_NUM_SRC = 2;
  localparam int CDB_SRC_RS  = 0;
  localparam int CDB_SRC_LSB = 1;

  function automatic int cdb_src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of producer-side and broadcast-side signals of the CDB arbiter.
//   src_valid/src_ready/src_rob_id/src_data : per-source offer (packed, source 0 at LSBs)
//   cdb_en/cdb_rob_id/cdb_data/cdb_src      : broadcast to RS, LSB and ROB
// master = producers/consumers around the arbiter, slave = the arbiter itself.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = CDB_NUM_SRC,
  parameter int ROB_W      = cdb_arbiter_pkg::ROB_WIDTH,
  parameter int DATA_W     = cdb_arbiter_pkg::DATA_WIDTH,
  parameter int SRC_W      = cdb_src_w(NUM_SRC)
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*ROB_W-1:0]  src_rob_id;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      cdb_en;
  logic [ROB_W-1:0]          cdb_rob_id;
  logic [DATA_W-1:0]         cdb_data;
  logic [SRC_W-1:0]          cdb_src;

  modport master (
    output src_valid, src_rob_id, src_data,
    input  src_ready, cdb_en, cdb_rob_id, cdb_data, cdb_src
  );

  modport slave (
    input  src_valid, src_rob_id, src_data,
    output src_ready, cdb_en, cdb_rob_id, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_fifo.sv
// Per-source result queue of the CDB arbiter.
//   clk_in, rst_n_in : clock, asynchronous active-low reset (pointers/count only)
//   push, din        : enqueue din at the tail
//   pop              : dequeue the head
//   clear            : empty the queue (wins over push/pop)
//   head, count      : current head entry and occupancy 0..DEPTH
// Callers guarantee push only when not full and pop only when not empty.
module cdb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + PW'(1);
      if (pop)  r_rptr <= r_rptr + PW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk_in) begin
    if (push && !clear) r_mem[r_wptr] <= din;
  end

  assign head  = r_mem[r_rptr];
  assign count = r_count;
endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus scheduler: queues results from NUM_SRC producers and broadcasts
// at most one per cycle, picking round-robin among non-empty queues.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   rdy_in           : global enable, low freezes all state
//   flush            : mispredict flush, empties every queue and resets rr pointer
//   bus (slave)      : producer offers and CDB broadcast, see cdb_arbiter_if
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = CDB_NUM_SRC,
  parameter int DEPTH      = 4,
  parameter int ROB_WIDTH  = cdb_arbiter_pkg::ROB_WIDTH,
  parameter int DATA_WIDTH = cdb_arbiter_pkg::DATA_WIDTH
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         rdy_in,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int EW    = ROB_WIDTH + DATA_WIDTH;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int SRC_W = cdb_src_w(NUM_SRC);

  logic [EW-1:0]      w_head [NUM_SRC];
  logic [CW-1:0]      w_count [NUM_SRC];
  logic [NUM_SRC-1:0] w_ready;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic [NUM_SRC-1:0] w_nonempty;
  logic               w_active;
  logic               w_any;
  logic               w_clear;
  logic [SRC_W-1:0]   w_grant;
  logic [SRC_W-1:0]   r_rr_ptr;

  assign w_active = rdy_in && !flush;
  // A frozen core keeps its queues even if flush is raised meanwhile.
  assign w_clear  = rdy_in && flush;

  genvar g;
  for (g = 0; g < NUM_SRC; g++) begin : g_src
    // Ready looks at the registered count only; a pop in the same cycle does not help.
    assign w_ready[g]    = w_active && (w_count[g] < CW'(DEPTH));
    assign w_nonempty[g] = (w_count[g] != '0);
    assign w_push[g]     = w_ready[g] && bus.src_valid[g];
    assign w_pop[g]      = bus.cdb_en && (w_grant == SRC_W'(g));

    cdb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .push     (w_push[g]),
      .pop      (w_pop[g]),
      .clear    (w_clear),
      .din      ({bus.src_rob_id[g*ROB_WIDTH +: ROB_WIDTH],
                  bus.src_data[g*DATA_WIDTH +: DATA_WIDTH]}),
      .head     (w_head[g]),
      .count    (w_count[g])
    );
  end

  // First non-empty queue scanning rr_ptr, rr_ptr+1, ... mod NUM_SRC.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!w_any && w_nonempty[(int'(r_rr_ptr) + k) % NUM_SRC]) begin
        w_any   = 1'b1;
        w_grant = SRC_W'((int'(r_rr_ptr) + k) % NUM_SRC);
      end
    end
  end

  assign bus.src_ready  = w_ready;
  assign bus.cdb_en     = w_active && w_any;
  assign bus.cdb_rob_id = bus.cdb_en ? w_head[w_grant][EW-1 -: ROB_WIDTH] : '0;
  assign bus.cdb_data   = bus.cdb_en ? w_head[w_grant][DATA_WIDTH-1:0] : '0;
  assign bus.cdb_src    = bus.cdb_en ? w_grant : '0;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rr_ptr <= '0;
    end else if (w_clear) begin
      r_rr_ptr <= '0;
    end else if (bus.cdb_en) begin
      r_rr_ptr <= SRC_W'((int'(w_grant) + 1) % NUM_SRC);
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  logic rdy;
  logic flush;
  int   cyc;
  int   n_chk;
  int   n_fail;

  logic [36:0] exp0[$];
  logic [36:0] exp1[$];
  logic [4:0]  log_rob[$];
  int          log_cyc[$];

  cdb_arbiter_if #(.NUM_SRC(2), .ROB_W(5), .DATA_W(32)) bus ();

  cdb_arbiter #(
    .NUM_SRC    (2),
    .DEPTH      (4),
    .ROB_WIDTH  (5),
    .DATA_WIDTH (32)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .flush    (flush),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dat(input logic [4:0] t);
    return 32'hCAFE_0000 | {27'd0, t};
  endfunction

  // Scoreboard monitor: every broadcast must match the head of that source's expected queue.
  always @(negedge clk) begin
    if (bus.cdb_en === 1'b1) begin
      log_rob.push_back(bus.cdb_rob_id);
      log_cyc.push_back(cyc);
      if (bus.cdb_src == 1'(CDB_SRC_RS)) begin
        if (exp0.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_src0: got rob %0h data %0h expected nothing", bus.cdb_rob_id, bus.cdb_data);
        end else chk("cdb_src0_entry", {bus.cdb_rob_id, bus.cdb_data}, exp0.pop_front());
      end else begin
        if (exp1.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_src1: got rob %0h data %0h expected nothing", bus.cdb_rob_id, bus.cdb_data);
        end else chk("cdb_src1_entry", {bus.cdb_rob_id, bus.cdb_data}, exp1.pop_front());
      end
    end else begin
      chk("cdb_idle_zero", {bus.cdb_rob_id, bus.cdb_data, bus.cdb_src}, 64'd0);
    end
  end

  // Offer one cycle of inputs; accepted entries go to the scoreboard.
  task automatic step(input logic [1:0] v, input logic [4:0] t0, input logic [4:0] t1,
                      output logic [1:0] acc);
    bus.src_valid  = v;
    bus.src_rob_id = {t1, t0};
    bus.src_data   = {dat(t1), dat(t0)};
    @(negedge clk);
    acc = v & bus.src_ready;
    if (acc[0]) exp0.push_back({t0, dat(t0)});
    if (acc[1]) exp1.push_back({t1, dat(t1)});
    @(posedge clk); #1;
    bus.src_valid = '0;
  endtask

  task automatic idle(input int n);
    logic [1:0] a;
    for (int i = 0; i < n; i++) step(2'b00, 5'd0, 5'd0, a);
  endtask

  initial begin
    logic [1:0] acc;
    int k0, k1;
    logic saw_full;
    logic [4:0] exp_order[6];

    n_chk = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    bus.src_valid = '0; bus.src_rob_id = '0; bus.src_data = '0;

    // Power-on reset state
    #12;
    chk("reset_cdb_en", bus.cdb_en, 1'b0);
    chk("reset_outputs", {bus.cdb_rob_id, bus.cdb_data, bus.cdb_src}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", bus.src_ready, 2'b11);
    @(posedge clk); #1;

    // 1. Reset mid-stream
    step(2'b11, 5'd20, 5'd21, acc);
    step(2'b11, 5'd22, 5'd23, acc);
    rst_n = 1'b0;
    #1;
    chk("midreset_cdb_en", bus.cdb_en, 1'b0);
    exp0.delete(); exp1.delete();
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_ready", bus.src_ready, 2'b11);
    chk("midreset_empty", bus.cdb_en, 1'b0);
    @(negedge clk);
    chk("midreset_still_empty", bus.cdb_en, 1'b0);
    @(posedge clk); #1;

    // 3. Contention with rr_ptr=0
    log_rob.delete(); log_cyc.delete();
    step(2'b11, 5'd1, 5'd9, acc);
    step(2'b11, 5'd2, 5'd10, acc);
    step(2'b11, 5'd3, 5'd11, acc);
    idle(4);
    exp_order = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
    chk("contention_count", log_rob.size(), 6);
    for (int i = 0; i < 6 && i < log_rob.size(); i++) begin
      chk("contention_order", log_rob[i], exp_order[i]);
      chk("contention_no_gap", log_cyc[i] - log_cyc[0], i);
    end

    // 2. Single source, one-cycle latency, no bypass
    bus.src_valid = 2'b01; bus.src_rob_id = {5'd0, 5'd3}; bus.src_data = {32'd0, 32'h11};
    @(negedge clk);
    chk("single_no_bypass", bus.cdb_en, 1'b0);
    exp0.push_back({5'd3, 32'h11});
    @(posedge clk); #1;
    bus.src_valid = '0;
    @(negedge clk);
    chk("single_bcast", {bus.cdb_en, bus.cdb_rob_id, bus.cdb_data, bus.cdb_src}, {1'b1, 5'd3, 32'h11, 1'b0});
    @(negedge clk);
    chk("single_once", bus.cdb_en, 1'b0);
    @(posedge clk); #1;

    // 4. Both sources push every cycle until queues fill
    k0 = 0; k1 = 0; saw_full = 1'b0;
    for (int c = 0; c < 60 && (k0 < 8 || k1 < 8); c++) begin
      chk("full_ready0", bus.src_ready[0], exp0.size() < 4);
      chk("full_ready1", bus.src_ready[1], exp1.size() < 4);
      if (bus.src_ready != 2'b11) saw_full = 1'b1;
      step({k1 < 8, k0 < 8}, 5'(16 + k0), 5'(24 + k1), acc);
      k0 += int'(acc[0]);
      k1 += int'(acc[1]);
    end
    chk("full_all_offered", {k0[7:0], k1[7:0]}, {8'd8, 8'd8});
    chk("full_reached", saw_full, 1'b1);
    idle(12);
    chk("full_drained", exp0.size() + exp1.size(), 0);

    // 5. Flush discards queued entries and the flush-cycle inputs
    for (int i = 0; i < 5; i++) step(2'b11, 5'(1 + i), 5'(8 + i), acc);
    flush = 1'b1;
    bus.src_valid = 2'b11; bus.src_rob_id = {5'd31, 5'd30}; bus.src_data = {dat(5'd31), dat(5'd30)};
    @(negedge clk);
    chk("flush_cdb_en", bus.cdb_en, 1'b0);
    chk("flush_ready", bus.src_ready, 2'b00);
    @(posedge clk); #1;
    flush = 1'b0; bus.src_valid = '0;
    exp0.delete(); exp1.delete();
    @(negedge clk);
    chk("post_flush_empty", bus.cdb_en, 1'b0);
    chk("post_flush_ready", bus.src_ready, 2'b11);
    @(posedge clk); #1;
    idle(3);

    // 6. Stall with rdy_in low
    log_rob.delete(); log_cyc.delete();
    step(2'b01, 5'd5, 5'd0, acc);
    rdy = 1'b0;
    bus.src_valid = 2'b01; bus.src_rob_id = {5'd0, 5'd6}; bus.src_data = {32'd0, dat(5'd6)};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_cdb_en", bus.cdb_en, 1'b0);
      chk("stall_ready", bus.src_ready, 2'b00);
    end
    @(posedge clk); #1;
    rdy = 1'b1;
    step(2'b01, 5'd6, 5'd0, acc);
    idle(3);
    chk("stall_count", log_rob.size(), 2);
    if (log_rob.size() >= 2) begin
      chk("stall_first", log_rob[0], 5'd5);
      chk("stall_second", log_rob[1], 5'd6);
    end

    for (int i = 0; i < 20 && (exp0.size() != 0 || exp1.size() != 0); i++) @(posedge clk);
    chk("final_src0_drained", exp0.size(), 0);
    chk("final_src1_drained", exp1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
